triangle_dispatcher: RTL and testbench

//  Upstream feeder for the rasterizer. Buffers incoming Triangle3D/Color pairs in a small FIFO.

---
 rtl/triangle_dispatcher_pkg.sv | 36 +++
 rtl/triangle_dispatcher_if.sv | 42 ++++
 rtl/triangle_dispatcher_tri_fifo.sv | 72 +++++++
 rtl/triangle_dispatcher.sv | 86 ++++++++
 tb/tb_triangle_dispatcher.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/triangle_dispatcher_pkg.sv
// Shared types for the triangle dispatcher slice.
//   Vertex3D / Triangle3D : signed 16-bit fixed-point geometry handed to the rasterizer
//   Color                 : 8-bit color index paired with each triangle
//   tri_entry_t           : one queued {triangle, color} pair as stored in the FIFO
//   DispatchState_t       : dispatcher FSM states
//   DISPATCH_DEPTH        : default FIFO depth (power of 2, >= 2)
package triangle_dispatcher_pkg;

  localparam int DISPATCH_DEPTH = 4;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef logic [7:0] Color;

  typedef struct packed {
    Triangle3D tri3d;
    Color      col;
  } tri_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } DispatchState_t;

endpackage

// File: rtl/triangle_dispatcher_if.sv
// Bus between the geometry stage / rasterizer and the triangle dispatcher.
//   in_valid/in_ready/in_triangle/in_color : upstream push channel
//   flush                                  : discard every queued (not in-flight) entry
//   o_triangle/o_color/start/rast_done     : rasterizer launch channel
//   busy/count/dbg_state                   : status and FSM state observation
// Handshake: a push happens on a rising edge where in_valid && in_ready. in_ready
// depends only on registered occupancy (never on in_valid or a same-cycle pop).
// in_valid/in_triangle/in_color must stay stable while in_valid is high and
// in_ready is low. start is a one-cycle pulse; o_triangle/o_color stay stable
// from start until the edge where rast_done is seen.
interface triangle_dispatcher_if
  import triangle_dispatcher_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  Triangle3D        in_triangle;
  Color             in_color;
  logic             flush;
  Triangle3D        o_triangle;
  Color             o_color;
  logic             start;
  logic             rast_done;
  logic             busy;
  logic [CNT_W-1:0] count;
  DispatchState_t   dbg_state;

  // Dispatcher side
  modport slave (
    input  in_valid, in_triangle, in_color, flush, rast_done,
    output in_ready, o_triangle, o_color, start, busy, count, dbg_state
  );

  // Geometry stage + rasterizer side
  modport master (
    output in_valid, in_triangle, in_color, flush, rast_done,
    input  in_ready, o_triangle, o_color, start, busy, count, dbg_state
  );
endinterface

// File: rtl/triangle_dispatcher_tri_fifo.sv
// Small circular FIFO of {triangle, color} entries.
//   clk, n_rst : clock, async active-low reset
//   i_push     : write request (ignored when full or flushing)
//   i_pop      : read request (ignored when empty or flushing)
//   i_flush    : drop all stored entries this edge
//   i_wdata    : entry to write
//   o_rdata    : entry at the read pointer (combinational view of storage)
//   o_count    : occupancy, 0..DEPTH
//   o_full     : count == DEPTH
//   o_empty    : count == 0
module tri_fifo
  import triangle_dispatcher_pkg::*;
#(
  parameter  int DEPTH = DISPATCH_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  tri_entry_t       i_wdata,
  output tri_entry_t       o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  tri_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // Flush wins over both push and pop so the queue is exactly empty afterwards.
  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of 2.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/triangle_dispatcher.sv
// Upstream feeder for the rasterizer: queues triangle/color pairs and launches
// them one at a time, holding each on o_triangle/o_color until rast_done.
//   clk, n_rst : clock, async active-low reset
//   bus        : triangle_dispatcher_if.slave (push channel, flush, launch
//                channel, busy/count/dbg_state status)
module triangle_dispatcher
  import triangle_dispatcher_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  triangle_dispatcher_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  DispatchState_t   r_state;
  DispatchState_t   w_next_state;
  logic             w_pop;
  tri_entry_t       w_head;
  tri_entry_t       w_wdata;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  Triangle3D        r_triangle;
  Color             r_color;

  assign w_wdata = '{tri3d: bus.in_triangle, col: bus.in_color};

  tri_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_push  (bus.in_valid),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // rast_done only matters in WAIT; a pulse seen in IDLE or LAUNCH is dropped.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !bus.flush) begin
          w_next_state = LAUNCH;
          w_pop        = 1'b1;
        end
      end
      LAUNCH:  w_next_state = WAIT;
      WAIT:    if (bus.rast_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Launch registers load only on the pop edge, so they hold through WAIT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_triangle <= '0;
      r_color    <= '0;
    end else if (w_pop) begin
      r_triangle <= w_head.tri3d;
      r_color    <= w_head.col;
    end
  end

  // start and busy decode the registered state only: no path from in_valid
  // or rast_done reaches them combinationally.
  assign bus.start      = (r_state == LAUNCH);
  assign bus.busy       = (r_state != IDLE);
  assign bus.in_ready   = !w_full;
  assign bus.count      = w_count;
  assign bus.o_triangle = r_triangle;
  assign bus.o_color    = r_color;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_triangle_dispatcher.sv
module tb_triangle_dispatcher;
  import triangle_dispatcher_pkg::*;

  localparam int DEPTH = DISPATCH_DEPTH;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  triangle_dispatcher_if #(.DEPTH(DEPTH)) bus ();

  triangle_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Queue-level view: pending entries, whether a triangle is out at the
  // rasterizer, and whether this is its launch cycle.
  tri_entry_t exp_q[$];   // expected issue order, popped by the monitor
  tri_entry_t mq[$];      // entries waiting in the dispatcher
  tri_entry_t m_cur;
  tri_entry_t m_new;
  bit         m_busy, m_start, m_do_pop, m_do_push, m_done;
  int         m_n;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      exp_q.delete();
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_cur   = '0;
    end else begin
      m_do_pop  = !m_busy && (mq.size() != 0) && !bus.flush;
      m_do_push = bus.in_valid && (mq.size() < DEPTH) && !bus.flush;
      m_done    = m_busy && !m_start && bus.rast_done;
      if (bus.flush) begin
        // Queued entries are the newest tail of the expected issue order.
        m_n = mq.size();
        for (int i = 0; i < m_n; i++) void'(exp_q.pop_back());
        mq.delete();
      end
      if (m_do_pop) m_cur = mq.pop_front();
      if (m_do_push) begin
        m_new = '{tri3d: bus.in_triangle, col: bus.in_color};
        mq.push_back(m_new);
        exp_q.push_back(m_new);
      end
      m_start = m_do_pop;
      if (m_do_pop)    m_busy = 1'b1;
      else if (m_done) m_busy = 1'b0;
    end
  end

  // ---------------- rasterizer stub ----------------
  bit rast_hold  = 1'b1;   // bench drives rast_done by hand
  bit rast_noise = 1'b0;   // random rast_done pulses while nothing is armed
  bit rast_rand  = 1'b0;
  int rast_delay = 10;
  bit r_armed    = 1'b0;
  int r_cnt      = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rast_hold) begin
        if (r_armed) begin
          if (r_cnt <= 0) begin
            bus.rast_done = 1'b1;
            r_armed       = 1'b0;
          end else begin
            bus.rast_done = 1'b0;
            r_cnt--;
          end
        end else begin
          bus.rast_done = rast_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         n_starts = 0;
  tri_entry_t mon_e;

  always @(negedge clk) begin
    if (n_rst) begin
      check("start",    160'(bus.start),    160'(m_start));
      check("busy",     160'(bus.busy),     160'(m_busy));
      check("count",    160'(bus.count),    160'(mq.size()));
      check("in_ready", 160'(bus.in_ready), 160'(mq.size() < DEPTH));
      if (m_busy) begin
        check("held_triangle", 160'(bus.o_triangle), 160'(m_cur.tri3d));
        check("held_color",    160'(bus.o_color),    160'(m_cur.col));
      end
      if (bus.start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          fail_now("spurious_start");
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_triangle", 160'(bus.o_triangle), 160'(mon_e.tri3d));
          check("issue_color",    160'(bus.o_color),    160'(mon_e.col));
        end
        if (!rast_hold) begin
          r_armed = 1'b1;
          r_cnt   = (rast_rand ? int'($urandom_range(1, 20)) : rast_delay) - 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic tri_entry_t rand_entry();
    tri_entry_t   e;
    logic [159:0] r;
    r       = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e.tri3d = r[143:0];
    e.col   = 8'($urandom);
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called and returns at posedge+1.
  task automatic drive_push(input tri_entry_t e, input int budget);
    bit ok;
    ok              = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_triangle = e.tri3d;
    bus.in_color    = e.col;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("push_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic release_rast();
    rast_hold     = 1'b0;
    bus.rast_done = 1'b0;
    if (m_busy) begin
      r_armed = 1'b1;
      r_cnt   = rast_delay - 1;
    end
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mq.size() == 0 && !m_busy) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  tri_entry_t t0, e;
  int         starts_before;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_triangle = '0;
    bus.in_color    = '0;
    bus.flush       = 1'b0;
    bus.rast_done   = 1'b0;

    // Reset state
    #1;
    check("rst_start",    160'(bus.start),      160'(0));
    check("rst_busy",     160'(bus.busy),       160'(0));
    check("rst_count",    160'(bus.count),      160'(0));
    check("rst_in_ready", 160'(bus.in_ready),   160'(1));
    check("rst_triangle", 160'(bus.o_triangle), 160'(0));
    check("rst_color",    160'(bus.o_color),    160'(0));
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(2);

    // Single triangle: start two edges after the push, held while waiting
    rast_hold     = 1'b0;
    rast_delay    = 10;
    t0            = rand_entry();
    t0.col        = 8'h1F;
    starts_before = n_starts;
    drive_push(t0, 4);
    @(negedge clk);
    check("single_no_start_yet", 160'(bus.start), 160'(0));
    check("single_count1",       160'(bus.count), 160'(1));
    @(negedge clk);
    check("single_start",    160'(bus.start),      160'(1));
    check("single_triangle", 160'(bus.o_triangle), 160'(t0.tri3d));
    check("single_color",    160'(bus.o_color),    160'(8'h1F));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("single_hold", 160'(bus.o_triangle), 160'(t0.tri3d));
      check("single_start_low", 160'(bus.start), 160'(0));
    end
    @(posedge clk);
    #1;
    wait_drain(50);
    check("single_start_count", 160'(n_starts - starts_before), 160'(1));
    check("single_busy_drop",   160'(bus.busy),                 160'(0));

    // Fill with the rasterizer stalled; the sixth push waits for a pop
    rast_hold     = 1'b1;
    bus.rast_done = 1'b0;
    rast_delay    = 3;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_push(rand_entry(), 60);
      end
      begin
        idle(8);
        check("fill_count",    160'(bus.count),    160'(DEPTH));
        check("fill_in_ready", 160'(bus.in_ready), 160'(0));
        check("fill_busy",     160'(bus.busy),     160'(1));
        idle(3);
        check("fill_still_full", 160'(bus.count), 160'(DEPTH));
        release_rast();
      end
    join
    wait_drain(500);

    // Push on the pop edge keeps count
    rast_hold = 1'b1;
    for (int i = 0; i < 3; i++) drive_push(rand_entry(), 10);
    idle(2);
    check("simul_pre_count", 160'(bus.count), 160'(2));
    bus.rast_done = 1'b1;
    idle(1);
    bus.rast_done   = 1'b0;
    e               = rand_entry();
    bus.in_valid    = 1'b1;
    bus.in_triangle = e.tri3d;
    bus.in_color    = e.col;
    idle(1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("simul_count", 160'(bus.count), 160'(2));
    check("simul_start", 160'(bus.start), 160'(1));
    @(posedge clk);
    #1;
    release_rast();
    wait_drain(500);

    // Flush during WAIT with a colliding push
    rast_hold = 1'b1;
    for (int i = 0; i < 4; i++) drive_push(rand_entry(), 10);
    idle(2);
    check("flush_pre_count", 160'(bus.count), 160'(3));
    e               = rand_entry();
    bus.flush       = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_triangle = e.tri3d;
    bus.in_color    = e.col;
    starts_before   = n_starts;
    idle(1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_count",    160'(bus.count), 160'(0));
    check("flush_inflight", 160'(bus.busy),  160'(1));
    @(posedge clk);
    #1;
    release_rast();
    idle(25);
    check("flush_no_start", 160'(n_starts - starts_before), 160'(0));
    check("flush_idle",     160'(bus.busy),                 160'(0));

    // Asynchronous reset mid-WAIT with three queued
    rast_hold = 1'b1;
    for (int i = 0; i < 4; i++) drive_push(rand_entry(), 10);
    idle(2);
    check("rst2_pre_count", 160'(bus.count), 160'(3));
    check("rst2_pre_busy",  160'(bus.busy),  160'(1));
    #3;
    n_rst = 1'b0;
    #1;
    check("rst2_start",    160'(bus.start),      160'(0));
    check("rst2_busy",     160'(bus.busy),       160'(0));
    check("rst2_count",    160'(bus.count),      160'(0));
    check("rst2_in_ready", 160'(bus.in_ready),   160'(1));
    check("rst2_triangle", 160'(bus.o_triangle), 160'(0));
    check("rst2_color",    160'(bus.o_color),    160'(0));
    @(posedge clk);
    #1;
    n_rst   = 1'b1;
    r_armed = 1'b0;
    idle(2);

    // Wrap: ten triangles, random rasterizer latency and stray rast_done
    rast_hold     = 1'b0;
    rast_rand     = 1'b1;
    rast_noise    = 1'b1;
    starts_before = n_starts;
    for (int i = 0; i < 10; i++) begin
      drive_push(rand_entry(), 200);
      idle($urandom_range(0, 3));
    end
    wait_drain(2000);
    check("wrap_starts", 160'(n_starts - starts_before), 160'(10));
    rast_noise = 1'b0;
    idle(3);

    check("final_exp_q_empty", 160'(exp_q.size()), 160'(0));
    check("final_count",       160'(bus.count),    160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
